// File: rtl/ddr_act_sched.sv
//==============================================================================
// Module      : ddr_act_sched
// Description : Epoch sequencer between the activation source memory, the MIG
//               UI wrapper and the DNN. Each epoch it waits for calibration,
//               strikes a write burst (advancing the source address on every
//               wdf_ack), waits a fixed gap, strikes a read burst and enables
//               the DNN on every valid read beat. A no-progress timeout parks
//               the FSM in a sticky error state.
// Ports       : clk/reset          - ui_clk, async active-high ui_rst
//               start              - one-cycle run request (IDLE/DONE only)
//               init_calib_complete, wdf_ack, wr_done, rd_data_valid, rd_done
//                                  - MIG UI status inputs
//               mem_wen_strike / mem_ren_strike - one-cycle burst strikes
//               src_addr           - source-memory address (write data index)
//               dnn_en             - DNN clock-enable (rd_data_valid in RD_RUN)
//               epoch_cnt          - completed epochs
//               busy / done / err  - status, done pulse, sticky timeout flag
//               rd_cnt_err         - sticky beat-count error (optional)
// Options     : `define RD_BEAT_CHECK_EN adds a read-beat counter and the
//               rd_cnt_err output.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ddr_act_sched #(
    parameter int ADDR_W     = 20,
    parameter int NUM_BEATS  = 16384,
    parameter int GAP_CYCLES = 2,
    parameter int NUM_EPOCHS = 1,
    parameter int TO_W       = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              init_calib_complete,
    input  logic              wdf_ack,
    input  logic              wr_done,
    input  logic              rd_data_valid,
    input  logic              rd_done,
    output logic              mem_wen_strike,
    output logic              mem_ren_strike,
    output logic [ADDR_W-1:0] src_addr,
    output logic              dnn_en,
    output logic [15:0]       epoch_cnt,
    output logic              busy,
    output logic              done,
`ifdef RD_BEAT_CHECK_EN
    output logic              rd_cnt_err,
`endif
    output logic              err
);

    localparam int                c_gap_w      = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam logic [ADDR_W-1:0] c_last_addr  = ADDR_W'(NUM_BEATS - 1);
    // Expiry is detected one count early so err rises on the cycle the
    // counter would reach all-ones.
    localparam logic [TO_W-1:0]   c_to_limit   = {{(TO_W-1){1'b1}}, 1'b0};
    localparam logic [TO_W-1:0]   c_to_ones    = {TO_W{1'b1}};
    localparam logic [c_gap_w-1:0] c_gap_load  = c_gap_w'(GAP_CYCLES);
    localparam logic [c_gap_w-1:0] c_gap_one   = c_gap_w'(1);
    localparam logic [15:0]       c_last_epoch = 16'(NUM_EPOCHS - 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WAIT_CAL  = 4'd1,
        S_WR_STRIKE = 4'd2,
        S_WR_RUN    = 4'd3,
        S_GAP       = 4'd4,
        S_RD_STRIKE = 4'd5,
        S_RD_RUN    = 4'd6,
        S_NEXT      = 4'd7,
        S_DONE      = 4'd8,
        S_ERR       = 4'd9
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_src_addr;
    logic [15:0]         r_epoch_cnt;
    logic [TO_W-1:0]     r_to_cnt;
    logic [c_gap_w-1:0]  r_gap_cnt;
    logic                r_wen_strike;
    logic                r_ren_strike;
    logic                r_done;
    logic                r_err;
    logic                w_to_expire;

    assign w_to_expire = (r_to_cnt == c_to_limit);

`ifdef RD_BEAT_CHECK_EN
    logic [31:0] r_beat_cnt;
    logic        r_rd_cnt_err;
    logic [31:0] w_beat_total;

    // Includes a beat that coincides with rd_done.
    assign w_beat_total = r_beat_cnt + 32'(rd_data_valid);
    assign rd_cnt_err   = r_rd_cnt_err;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_src_addr   <= '0;
            r_epoch_cnt  <= '0;
            r_to_cnt     <= '0;
            r_gap_cnt    <= '0;
            r_wen_strike <= 1'b0;
            r_ren_strike <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
`ifdef RD_BEAT_CHECK_EN
            r_beat_cnt   <= '0;
            r_rd_cnt_err <= 1'b0;
`endif
        end else begin
            r_wen_strike <= 1'b0;
            r_ren_strike <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_WAIT_CAL;
                        r_epoch_cnt <= '0;
                        r_src_addr  <= '0;
                        r_to_cnt    <= '0;
                    end
                end
                S_WAIT_CAL: begin
                    if (init_calib_complete) begin
                        r_state      <= S_WR_STRIKE;
                        r_wen_strike <= 1'b1;
                        r_to_cnt     <= '0;
                    end else if (w_to_expire) begin
                        r_state  <= S_ERR;
                        r_err    <= 1'b1;
                        r_to_cnt <= c_to_ones;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                S_WR_STRIKE: begin
                    r_state  <= S_WR_RUN;
                    r_to_cnt <= '0;
                end
                S_WR_RUN: begin
                    if (wdf_ack && (r_src_addr != c_last_addr)) begin
                        r_src_addr <= r_src_addr + ADDR_W'(1);
                    end
                    if (wr_done) begin
                        r_to_cnt <= '0;
                        if (GAP_CYCLES == 0) begin
                            r_state      <= S_RD_STRIKE;
                            r_ren_strike <= 1'b1;
                        end else begin
                            r_state   <= S_GAP;
                            r_gap_cnt <= c_gap_load;
                        end
                    end else if (wdf_ack) begin
                        r_to_cnt <= '0;
                    end else if (w_to_expire) begin
                        r_state  <= S_ERR;
                        r_err    <= 1'b1;
                        r_to_cnt <= c_to_ones;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                S_GAP: begin
                    // GAP lasts exactly GAP_CYCLES cycles.
                    if (r_gap_cnt <= c_gap_one) begin
                        r_state      <= S_RD_STRIKE;
                        r_ren_strike <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - c_gap_one;
                    end
                end
                S_RD_STRIKE: begin
                    r_state  <= S_RD_RUN;
                    r_to_cnt <= '0;
`ifdef RD_BEAT_CHECK_EN
                    r_beat_cnt <= '0;
`endif
                end
                S_RD_RUN: begin
`ifdef RD_BEAT_CHECK_EN
                    r_beat_cnt <= w_beat_total;
                    if (rd_done && (w_beat_total != 32'(NUM_BEATS))) begin
                        r_rd_cnt_err <= 1'b1;
                    end
`endif
                    if (rd_done) begin
                        r_state  <= S_NEXT;
                        r_to_cnt <= '0;
                    end else if (rd_data_valid) begin
                        r_to_cnt <= '0;
                    end else if (w_to_expire) begin
                        r_state  <= S_ERR;
                        r_err    <= 1'b1;
                        r_to_cnt <= c_to_ones;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                S_NEXT: begin
                    r_epoch_cnt <= r_epoch_cnt + 16'd1;
                    r_src_addr  <= '0;
                    r_to_cnt    <= '0;
                    if (r_epoch_cnt == c_last_epoch) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_WAIT_CAL;
                    end
                end
                S_ERR: begin
                    r_state <= S_ERR;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_wen_strike = r_wen_strike;
    assign mem_ren_strike = r_ren_strike;
    assign src_addr       = r_src_addr;
    assign epoch_cnt      = r_epoch_cnt;
    assign done           = r_done;
    assign err            = r_err;
    // Zero-latency enable so the DNN steps on exactly the beat it receives.
    assign dnn_en         = (r_state == S_RD_RUN) && rd_data_valid;
    assign busy           = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERR);

endmodule

`default_nettype wire

// File: tb/tb_ddr_act_sched.sv
//==============================================================================
// Module      : tb_ddr_act_sched
// Description : Directed self-checking bench for ddr_act_sched. Instance A
//               (16 beats, gap 2, 1 epoch, 6-bit timeout) and instance B
//               (16 beats, gap 0, 3 epochs) share all inputs except start.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ddr_act_sched;

    logic clk;
    logic rst;
    logic start_a, start_b;
    logic calib, wdf_ack, wr_done, rd_data_valid, rd_done;

    logic        wen_a, ren_a, dnn_a, busy_a, done_a, err_a;
    logic [19:0] addr_a;
    logic [15:0] ep_a;
    logic        wen_b, ren_b, dnn_b, busy_b, done_b, err_b;
    logic [19:0] addr_b;
    logic [15:0] ep_b;
`ifdef RD_BEAT_CHECK_EN
    logic        rce_a, rce_b;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_wen_a = 0, n_ren_a = 0, n_dnn_a = 0, n_done_a = 0;
    int n_wen_b = 0, n_ren_b = 0, n_dnn_b = 0, n_done_b = 0;
    int b_wen, b_ren, b_dnn, b_done;

    ddr_act_sched #(
        .ADDR_W(20), .NUM_BEATS(16), .GAP_CYCLES(2), .NUM_EPOCHS(1), .TO_W(6)
    ) u_dut_a (
        .clk(clk), .reset(rst), .start(start_a),
        .init_calib_complete(calib), .wdf_ack(wdf_ack), .wr_done(wr_done),
        .rd_data_valid(rd_data_valid), .rd_done(rd_done),
        .mem_wen_strike(wen_a), .mem_ren_strike(ren_a), .src_addr(addr_a),
        .dnn_en(dnn_a), .epoch_cnt(ep_a), .busy(busy_a), .done(done_a),
`ifdef RD_BEAT_CHECK_EN
        .rd_cnt_err(rce_a),
`endif
        .err(err_a)
    );

    ddr_act_sched #(
        .ADDR_W(20), .NUM_BEATS(16), .GAP_CYCLES(0), .NUM_EPOCHS(3), .TO_W(8)
    ) u_dut_b (
        .clk(clk), .reset(rst), .start(start_b),
        .init_calib_complete(calib), .wdf_ack(wdf_ack), .wr_done(wr_done),
        .rd_data_valid(rd_data_valid), .rd_done(rd_done),
        .mem_wen_strike(wen_b), .mem_ren_strike(ren_b), .src_addr(addr_b),
        .dnn_en(dnn_b), .epoch_cnt(ep_b), .busy(busy_b), .done(done_b),
`ifdef RD_BEAT_CHECK_EN
        .rd_cnt_err(rce_b),
`endif
        .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (wen_a)  n_wen_a++;
        if (ren_a)  n_ren_a++;
        if (dnn_a)  n_dnn_a++;
        if (done_a) n_done_a++;
        if (wen_b)  n_wen_b++;
        if (ren_b)  n_ren_b++;
        if (dnn_b)  n_dnn_b++;
        if (done_b) n_done_b++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed time=%0t required<100000", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        calib = 1'b0; wdf_ack = 1'b0; wr_done = 1'b0; rd_data_valid = 1'b0; rd_done = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) tick();
        chk("rst_wen",   32'(wen_a),  0);
        chk("rst_ren",   32'(ren_a),  0);
        chk("rst_addr",  32'(addr_a), 0);
        chk("rst_epoch", 32'(ep_a),   0);
        chk("rst_busy",  32'(busy_a), 0);
        chk("rst_done",  32'(done_a), 0);
        chk("rst_err",   32'(err_a),  0);
        rst = 1'b0;
        tick();

        // ---------------- nominal run on A ----------------
        b_wen = n_wen_a; b_ren = n_ren_a; b_dnn = n_dnn_a; b_done = n_done_a;
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("nom_busy_after_start", 32'(busy_a), 1);
        chk("nom_b_stays_idle",     32'(busy_b), 0);
        repeat (8) tick();
        chk("nom_no_wen_before_cal", 32'(wen_a), 0);
        calib = 1'b1; tick();
        chk("nom_wen_1cyc_after_cal", 32'(wen_a), 1);
        tick();
        chk("nom_wen_one_cycle", 32'(wen_a), 0);
        // 20 acks: address saturates at 15; a start pulse mid-burst is ignored.
        for (int i = 0; i < 20; i++) begin
            wdf_ack = 1'b1;
            start_a = (i == 8);
            tick();
            start_a = 1'b0;
            if (i == 15) chk("nom_addr_after_16", 32'(addr_a), 15);
        end
        wdf_ack = 1'b0;
        chk("sat_addr_after_20", 32'(addr_a), 15);
        // Stray valid outside RD_RUN must not enable the DNN.
        rd_data_valid = 1'b1;
        wr_done = 1'b1; tick(); wr_done = 1'b0;
        tick();
        chk("gap_no_ren_early", 32'(ren_a), 0);
        tick();
        rd_data_valid = 1'b0;
        chk("gap_ren_3cyc_after_wrdone", 32'(ren_a), 1);
        tick();
        chk("ren_one_cycle", 32'(ren_a), 0);
        for (int i = 0; i < 16; i++) begin
            rd_data_valid = 1'b1;
            rd_done = (i == 15);
            #1;
            if (i == 0) chk("dnn_comb_follow_valid", 32'(dnn_a), 1);
            tick();
            rd_data_valid = 1'b0;
            rd_done = 1'b0;
            if ((i % 4) == 3 && i != 15) tick();
        end
        tick();
        chk("nom_done_pulse",  32'(done_a), 1);
        chk("nom_epoch_cnt",   32'(ep_a),   1);
        chk("nom_addr_zero",   32'(addr_a), 0);
        chk("nom_busy_low",    32'(busy_a), 0);
        tick();
        chk("nom_done_one_cycle", 32'(done_a), 0);
        chk("nom_dnn_beats",   32'(n_dnn_a - b_dnn),   16);
        chk("nom_wen_count",   32'(n_wen_a - b_wen),   1);
        chk("nom_ren_count",   32'(n_ren_a - b_ren),   1);
        chk("nom_done_count",  32'(n_done_a - b_done), 1);

`ifdef RD_BEAT_CHECK_EN
        // ---------------- short read burst (15 beats) ----------------
        chk("rce_clear_after_16", 32'(rce_a), 0);
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick(); tick();
        wr_done = 1'b1; tick(); wr_done = 1'b0;
        tick(); tick(); tick();
        for (int i = 0; i < 15; i++) begin
            rd_data_valid = 1'b1;
            rd_done = (i == 14);
            tick();
        end
        rd_data_valid = 1'b0; rd_done = 1'b0;
        tick();
        chk("rce_done_still_pulses", 32'(done_a), 1);
        chk("rce_set_after_15",      32'(rce_a),  1);
`endif

        // ---------------- timeout on A ----------------
        rst = 1'b1; tick(); rst = 1'b0; tick();
        b_ren = n_ren_a; b_wen = n_wen_a;
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick();
        chk("to_wen_strike", 32'(wen_a), 1);
        repeat (63) tick();
        chk("to_err_not_yet", 32'(err_a), 0);
        tick();
        chk("to_err_set",     32'(err_a),  1);
        chk("to_busy_low",    32'(busy_a), 0);
        start_a = 1'b1; tick(); start_a = 1'b0;
        repeat (3) tick();
        chk("to_err_sticky",     32'(err_a),  1);
        chk("to_start_ignored",  32'(busy_a), 0);
        chk("to_no_ren",         32'(n_ren_a - b_ren), 0);
        chk("to_single_wen",     32'(n_wen_a - b_wen), 1);

        // ---------------- reset mid RD_RUN on A ----------------
        rst = 1'b1; tick(); rst = 1'b0; tick();
        chk("rst_clears_err", 32'(err_a), 0);
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick(); tick();
        wr_done = 1'b1; tick(); wr_done = 1'b0;
        tick(); tick(); tick();
        b_dnn = n_dnn_a; b_wen = n_wen_a; b_ren = n_ren_a;
        rd_data_valid = 1'b1;
        #1;
        chk("mid_dnn_before_reset", 32'(dnn_a), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_dnn_async_zero", 32'(dnn_a),  0);
        chk("mid_busy_zero",      32'(busy_a), 0);
        for (int i = 0; i < 4; i++) begin
            rd_data_valid = ~rd_data_valid;
            tick();
        end
        rst = 1'b0;
        rd_data_valid = 1'b1;
        repeat (3) tick();
        rd_data_valid = 1'b0;
        chk("mid_idle_after_reset", 32'(busy_a), 0);
        chk("mid_no_dnn",    32'(n_dnn_a - b_dnn), 0);
        chk("mid_no_strike", 32'((n_wen_a - b_wen) + (n_ren_a - b_ren)), 0);

        // ---------------- three epochs on B (gap 0) ----------------
        b_wen = n_wen_b; b_ren = n_ren_b; b_dnn = n_dnn_b; b_done = n_done_b;
        start_b = 1'b1; tick(); start_b = 1'b0;
        for (int e = 0; e < 3; e++) begin
            for (int k = 0; k < 10 && !wen_b; k++) tick();
            chk("ep_wen_strike", 32'(wen_b), 1);
            tick();
            wdf_ack = 1'b1; repeat (3) tick(); wdf_ack = 1'b0;
            chk("ep_addr_3", 32'(addr_b), 3);
            wr_done = 1'b1; tick(); wr_done = 1'b0;
            chk("ep_gap0_ren_direct", 32'(ren_b), 1);
            tick();
            rd_data_valid = 1'b1; tick();
            rd_done = 1'b1; tick();
            rd_data_valid = 1'b0; rd_done = 1'b0;
            tick();
            chk("ep_addr_back_to_0", 32'(addr_b), 0);
            chk("ep_epoch_cnt",      32'(ep_b),   32'(e + 1));
        end
        tick();
        chk("ep_final_epoch", 32'(ep_b),   3);
        chk("ep_busy_low",    32'(busy_b), 0);
        chk("ep_wen_count",   32'(n_wen_b - b_wen),   3);
        chk("ep_ren_count",   32'(n_ren_b - b_ren),   3);
        chk("ep_dnn_count",   32'(n_dnn_b - b_dnn),   6);
        chk("ep_done_once",   32'(n_done_b - b_done), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
